// File: rtl/dm_pkg.sv
// ============================================================================
// Package   : dm
// Purpose   : Debug-module shared types. Holds the DMI request/response
//             encoding used by the JTAG DTM and its clock-domain crossing,
//             plus the types local to dmi_reg_adapter: the adapter state
//             enum, the timeout response data word and the register-bus
//             request struct.
// Revision  : 1.0 - initial release
// ============================================================================
`default_nettype none

package dm;

  // DMI operation field. The encoding 2'b11 is reserved.
  typedef enum logic [1:0] {
    DTM_NOP   = 2'h0,
    DTM_READ  = 2'h1,
    DTM_WRITE = 2'h2
  } dtm_op_e;

  // DMI response codes.
  localparam logic [1:0] DTM_SUCCESS = 2'h0;
  localparam logic [1:0] DTM_ERR     = 2'h2;
  localparam logic [1:0] DTM_BUSY    = 2'h3;

  typedef struct packed {
    logic [6:0]  addr;
    dtm_op_e     op;
    logic [31:0] data;
  } dmi_req_t;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } dmi_resp_t;

  // Adapter FSM states.
  typedef enum logic [1:0] {
    ADP_IDLE     = 2'd0,
    ADP_ISSUE    = 2'd1,
    ADP_WAIT_RSP = 2'd2,
    ADP_RESPOND  = 2'd3
  } adapter_state_e;

  // Data word returned when a register access is abandoned on timeout.
  localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

  // Register-bus request held for the duration of one access. The address
  // keeps the full DMI width; the adapter truncates it on the way out.
  typedef struct packed {
    logic        we;
    logic [6:0]  addr;
    logic [31:0] wdata;
  } reg_req_t;

endpackage : dm

`default_nettype wire

// File: rtl/dmi_reg_adapter.sv
// ============================================================================
// Module    : dmi_reg_adapter
// Purpose   : Core-clock consumer of the DMI request/response stream. Each
//             accepted DMI request becomes at most one access on a simple
//             req/gnt/rvalid register bus, and exactly one DMI response is
//             returned per accepted request. Out-of-range addresses and the
//             reserved op are rejected without touching the bus.
// Option    : DMI_REG_ADAPTER_TIMEOUT_EN - when defined, an access that has
//             not completed TimeoutCycles cycles after entering Issue is
//             abandoned and answered with {32'hDEAD_BEEF, DTM_ERR}.
// Ports     : clk_i, rst_i            clock, synchronous active-high reset
//             dmi_req_i/_valid_i/_ready_o    DMI request stream
//             dmi_resp_o/_valid_o/_ready_i   DMI response stream
//             reg_req_o, reg_we_o, reg_addr_o, reg_wdata_o  bus request
//             reg_gnt_i, reg_rvalid_i, reg_rdata_i, reg_err_i bus response
//             busy_o                   high whenever the FSM is not Idle
// Revision  : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmi_reg_adapter
  import dm::*;
#(
  parameter int unsigned AddrWidth     = 7,
  parameter logic [6:0]  MaxAddr       = 7'h7F,
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [$bits(dmi_req_t)-1:0]   dmi_req_i,
  input  logic                          dmi_req_valid_i,
  output logic                          dmi_req_ready_o,
  output logic [$bits(dmi_resp_t)-1:0]  dmi_resp_o,
  output logic                          dmi_resp_valid_o,
  input  logic                          dmi_resp_ready_i,
  output logic                          reg_req_o,
  output logic                          reg_we_o,
  output logic [AddrWidth-1:0]          reg_addr_o,
  output logic [31:0]                   reg_wdata_o,
  input  logic                          reg_gnt_i,
  input  logic                          reg_rvalid_i,
  input  logic [31:0]                   reg_rdata_i,
  input  logic                          reg_err_i,
  output logic                          busy_o
);

  adapter_state_e state_q, state_d;
  reg_req_t       bus_q, bus_d;
  dmi_resp_t      resp_q, resp_d;

  dmi_req_t       req_in;
  logic [1:0]     op_bits;
  logic           timeout_hit;

  assign req_in  = dmi_req_i;
  assign op_bits = req_in.op;

`ifdef DMI_REG_ADAPTER_TIMEOUT_EN
  localparam logic [15:0] TimeoutLimit = 16'(TimeoutCycles - 1);

  logic [15:0] cnt_q;

  // Held at zero outside the access states, so it reads zero in the first
  // Issue cycle and counts cycles spent in Issue + WaitRsp.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (state_q == ADP_ISSUE || state_q == ADP_WAIT_RSP) begin
      cnt_q <= cnt_q + 16'd1;
    end else begin
      cnt_q <= '0;
    end
  end

  // Compared with >= so that a grant arriving exactly at expiry (which wins)
  // still lets the following WaitRsp cycle time out instead of hanging.
  assign timeout_hit = (cnt_q >= TimeoutLimit);
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TimeoutCycles == 32'd0);
  assign timeout_hit        = 1'b0;
`endif

  // State register and latched request/response.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ADP_IDLE;
      bus_q   <= '0;
      resp_q  <= '0;
    end else begin
      state_q <= state_d;
      bus_q   <= bus_d;
      resp_q  <= resp_d;
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d          = state_q;
    bus_d            = bus_q;
    resp_d           = resp_q;
    dmi_req_ready_o  = 1'b0;
    dmi_resp_valid_o = 1'b0;
    reg_req_o        = 1'b0;
    busy_o           = 1'b1;

    case (state_q)
      ADP_IDLE: begin
        dmi_req_ready_o = 1'b1;
        busy_o          = 1'b0;
        if (dmi_req_valid_i) begin
          bus_d.we    = (op_bits == DTM_WRITE);
          bus_d.addr  = req_in.addr;
          bus_d.wdata = req_in.data;
          if (op_bits == DTM_NOP) begin
            resp_d  = '{data: 32'h0, resp: DTM_SUCCESS};
            state_d = ADP_RESPOND;
          end else if (op_bits == 2'b11 || req_in.addr > MaxAddr) begin
            resp_d  = '{data: 32'h0, resp: DTM_ERR};
            state_d = ADP_RESPOND;
          end else begin
            state_d = ADP_ISSUE;
          end
        end
      end

      ADP_ISSUE: begin
        reg_req_o = 1'b1;
        // rvalid alongside gnt is illegal on this bus and deliberately
        // not looked at here.
        if (reg_gnt_i) begin
          state_d = ADP_WAIT_RSP;
        end else if (timeout_hit) begin
          resp_d  = '{data: TIMEOUT_DATA, resp: DTM_ERR};
          state_d = ADP_RESPOND;
        end
      end

      ADP_WAIT_RSP: begin
        if (reg_rvalid_i) begin
          resp_d.resp = reg_err_i ? DTM_ERR : DTM_SUCCESS;
          resp_d.data = (!bus_q.we && !reg_err_i) ? reg_rdata_i : 32'h0;
          state_d     = ADP_RESPOND;
        end else if (timeout_hit) begin
          resp_d  = '{data: TIMEOUT_DATA, resp: DTM_ERR};
          state_d = ADP_RESPOND;
        end
      end

      ADP_RESPOND: begin
        dmi_resp_valid_o = 1'b1;
        if (dmi_resp_ready_i) begin
          state_d = ADP_IDLE;
        end
      end

      default: begin
        state_d = ADP_IDLE;
      end
    endcase
  end

  assign dmi_resp_o  = resp_q;
  assign reg_we_o    = bus_q.we;
  assign reg_addr_o  = bus_q.addr[AddrWidth-1:0];
  assign reg_wdata_o = bus_q.wdata;

endmodule : dmi_reg_adapter

`default_nettype wire

// File: doc/dmi_reg_adapter.md
Name: dmi_reg_adapter

Overview:
- Core-clock consumer of the DMI request/response stream produced by the JTAG DTM and its CDC.
- Accepts one dm::dmi_req_t at a time and translates it into a single access on a simple req/gnt/rvalid register bus.
- Returns exactly one dm::dmi_resp_t per accepted request.
- Adds address range checking and an optional response timeout, so a hung register target cannot wedge the debug path.

Parameters:
AddrWidth, 7, width of reg_addr_o (register word address); must be >= 1 and <= $bits(dm::dmi_req_t.addr)
MaxAddr, 7'h7F, highest legal DMI word address; addr > MaxAddr is rejected without a bus access
TimeoutCycles, 1024, cycles in Issue+WaitRsp before forced error response (range 2..65535)

Ports:
clk_i  in  1  core clock
rst_i  in  1  synchronous reset, active-high
dmi_req_i  in  $bits(dm::dmi_req_t)  DMI request (addr, data, op)
dmi_req_valid_i  in  1  request valid
dmi_req_ready_o  out  1  request accepted when valid&&ready
dmi_resp_o  out  $bits(dm::dmi_resp_t)  response (data, resp)
dmi_resp_valid_o  out  1  response valid
dmi_resp_ready_i  in  1  response consumed when valid&&ready
reg_req_o  out  1  register bus request
reg_we_o  out  1  1=write, 0=read
reg_addr_o  out  AddrWidth  register address
reg_wdata_o  out  32  write data
reg_gnt_i  in  1  request granted this cycle
reg_rvalid_i  in  1  access complete (read and write)
reg_rdata_i  in  32  read data, valid with reg_rvalid_i
reg_err_i  in  1  access error, valid with reg_rvalid_i
busy_o  out  1  high in any state other than Idle

Behaviour:
- Clocking and reset: single clock clk_i. Reset rst_i is synchronous and active-high.
- Reset values: FSM=Idle; reg_req_o=0; dmi_resp_valid_o=0; dmi_resp_o='0; reg_we_o=0; reg_addr_o='0; reg_wdata_o='0; busy_o=0; timeout counter=0.
- Reset asserted mid-operation: all outstanding state is dropped at the next edge. No response is emitted.
- FSM states: Idle, Issue, WaitRsp, Respond.
- Idle:
  - dmi_req_ready_o=1; it is 0 in every other state.
  - On handshake, latch addr, data and op.
  - op==DTM_NOP -> Respond with {data=0, resp=DTM_SUCCESS}.
  - op reserved (2'b11) or addr>MaxAddr -> Respond with {data=0, resp=DTM_ERR}.
  - Otherwise -> Issue.
- Issue:
  - reg_req_o=1; reg_we_o=(op==DTM_WRITE); reg_addr_o=addr[AddrWidth-1:0]; reg_wdata_o=data.
  - All of these stay stable until reg_gnt_i.
  - reg_gnt_i -> WaitRsp. reg_req_o falls on the next cycle.
- WaitRsp:
  - On reg_rvalid_i -> Respond.
  - resp = reg_err_i ? DTM_ERR : DTM_SUCCESS.
  - data = (read && !reg_err_i) ? reg_rdata_i : 32'h0.
  - reg_rvalid_i in the same cycle as reg_gnt_i is not legal on this bus and is ignored.
- Respond:
  - dmi_resp_valid_o=1 with dmi_resp_o held stable.
  - valid&&dmi_resp_ready_i -> Idle.
  - The next request can be accepted one cycle later.
- Latency: request accepted in cycle N -> reg_req_o in N+1. With gnt in N+1 and rvalid in N+2, response valid in N+3. NOP or rejected request: response valid in N+1.
- Stray response: reg_rvalid_i outside WaitRsp is ignored. It never generates a DMI response.
- Exactly one response per accepted request.

Optional Feature:
Macro: DMI_REG_ADAPTER_TIMEOUT_EN
- Defined:
  - A 16-bit counter clears on entry to Issue and increments each cycle in Issue or WaitRsp.
  - When the counter reaches TimeoutCycles-1 without gnt/rvalid completing: reg_req_o drops, FSM -> Respond with {data=32'hDEAD_BEEF, resp=DTM_ERR}.
  - A late reg_rvalid_i is then handled as a stray response.
  - A completion in the same cycle as expiry wins over the timeout.
- Not defined: no counter; the FSM waits in Issue/WaitRsp indefinitely and TimeoutCycles is unused.

Decomposition:
- dm package (existing): dmi_req_t, dmi_resp_t, dtm_op_e, DTM_* response codes.
- Add to dm package: the adapter state enum, the timeout data constant 32'hDEAD_BEEF, and the register-bus request struct {we, addr, wdata}.
- No sub-module: the FSM, latch registers and counter are a single module.

Test Plan:
- Read: addr 7'h11, op READ; reg_gnt_i in N+1, reg_rvalid_i in N+2 with rdata 32'hCAFE_0011 -> response {32'hCAFE_0011, SUCCESS} valid at N+3, reg_we_o=0 throughout.
- Write with backpressure: addr 7'h10, data 32'h8000_0001; gnt delayed 5 cycles; dmi_resp_ready_i low 3 cycles -> reg_req_o/addr/wdata stable 6 cycles, response {0, SUCCESS} held stable until ready, dmi_req_ready_o=0 until then.
- Rejection: MaxAddr=7'h40, request addr 7'h41 and an op=2'b11 -> each returns {0, DTM_ERR} at N+1 with no reg_req_o pulse; NOP -> {0, SUCCESS} at N+1.
- Bus error: read whose rvalid has reg_err_i=1 and rdata 32'h1234_5678 -> {0, DTM_ERR}.
- Timeout (macro on, TimeoutCycles=16): never grant -> reg_req_o drops and {32'hDEAD_BEEF, ERR} is valid 16 cycles after entering Issue; a later rvalid produces no response. Macro off: still waiting at cycle 1000.
- Reset mid-operation: rst_i asserted in WaitRsp -> next cycle Idle, all outputs at reset values, no response emitted; a subsequent read completes normally.
